pc_seq: RTL and testbench



---
 rtl/pc_seq.sv | 153 +++++++++++++++
 tb/tb_pc_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq -- parametrised program counter with call/return stack
//
// Generates the instruction/memory fetch address. Each enabled cycle the
// address either increments, loads a branch target, jumps to a call target
// (saving the return address on a LIFO), or pops a return address.
//
// Parameters
//   ADDR_W     address width; addr wraps modulo 2^ADDR_W
//   RESET_VEC  value loaded into addr on reset
//   STK_DEPTH  number of return-stack entries (1..16)
//   STK_PTR_W  width of stk_cnt; 2^STK_PTR_W must exceed STK_DEPTH
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         advance enable; 0 stalls, all state held, strobes dropped
//   brnch_yes  take branch this cycle
//   call       push addr+1 and jump to regBuf
//   ret        pop stack top into addr
//   regBuf     branch/call target
//   addr       current fetch address (registered)
//   stk_cnt    number of valid stack entries
//   stk_ovf    sticky: push attempted while full
//   stk_unf    sticky: pop attempted while empty
//
// Per-edge priority, highest first: rst, stall, ret, call, branch, increment.
//
// Optional feature (macro PC_REL_BRANCH_EN):
//   defined   -> brnch_yes adds regBuf (two's complement) to addr
//   undefined -> brnch_yes loads regBuf absolutely
//   call and ret always use absolute addresses.
// -----------------------------------------------------------------------------
module pc_seq #(
   parameter int unsigned          ADDR_W    = 8,
   parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
   parameter int unsigned          STK_DEPTH = 4,
   parameter int unsigned          STK_PTR_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 brnch_yes,
   input  logic                 call,
   input  logic                 ret,
   input  logic [ADDR_W-1:0]    regBuf,
   output logic [ADDR_W-1:0]    addr,
   output logic [STK_PTR_W-1:0] stk_cnt,
   output logic                 stk_ovf,
   output logic                 stk_unf
);

   // Stack index width; a 1-entry stack still needs a 1-bit index.
   localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

   localparam logic [ADDR_W-1:0]    ADDR_ONE = ADDR_W'(1);
   localparam logic [STK_PTR_W-1:0] CNT_ONE  = STK_PTR_W'(1);
   localparam logic [STK_PTR_W-1:0] CNT_FULL = STK_PTR_W'(STK_DEPTH);

   // Return-address LIFO; entry stk_cnt-1 is the top of stack.
   logic [ADDR_W-1:0] stack [STK_DEPTH];

   logic [ADDR_W-1:0]    addr_nxt;
   logic [ADDR_W-1:0]    addr_inc;
   logic [STK_PTR_W-1:0] cnt_nxt;
   logic                 ovf_nxt;
   logic                 unf_nxt;
   logic                 push;
   logic [IDX_W-1:0]     push_idx;
   logic [IDX_W-1:0]     pop_idx;

   // Sequential successor; also the pushed return address, so both wrap alike.
   assign addr_inc = addr + ADDR_ONE;

   // Index truncation is safe: push only happens while stk_cnt < STK_DEPTH,
   // and pop only while stk_cnt > 0.
   assign push_idx = IDX_W'(stk_cnt);
   assign pop_idx  = IDX_W'(stk_cnt - CNT_ONE);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      addr_nxt = addr_inc;
      cnt_nxt  = stk_cnt;
      ovf_nxt  = stk_ovf;
      unf_nxt  = stk_unf;
      push     = 1'b0;

      if (!en) begin
         // Stall: hold everything; strobes in this cycle are discarded.
         addr_nxt = addr;
      end else if (ret) begin
         // ret outranks call and brnch_yes.
         if (stk_cnt != '0) begin
            addr_nxt = stack[pop_idx];
            cnt_nxt  = stk_cnt - CNT_ONE;
         end else begin
            // Empty pop: fall through to sequential fetch and flag it.
            unf_nxt = 1'b1;
         end
      end else if (call) begin
         // The jump happens even when the push has to be dropped.
         addr_nxt = regBuf;
         if (stk_cnt < CNT_FULL) begin
            push    = 1'b1;
            cnt_nxt = stk_cnt + CNT_ONE;
         end else begin
            ovf_nxt = 1'b1;
         end
      end else if (brnch_yes) begin
`ifdef PC_REL_BRANCH_EN
         // Two's-complement offset; modular addition handles the sign.
         addr_nxt = addr + regBuf;
`else
         addr_nxt = regBuf;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Control state: address, stack pointer, sticky flags
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them
      // update from the same pre-edge values.
      if (rst) begin
         addr    <= RESET_VEC;
         stk_cnt <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         addr    <= addr_nxt;
         stk_cnt <= cnt_nxt;
         stk_ovf <= ovf_nxt;
         stk_unf <= unf_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Stack storage
   // -------------------------------------------------------------------------
   // NOTE: the stack array is deliberately not reset; stk_cnt alone defines
   // which entries are valid, so clearing the storage would buy nothing.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         stack[push_idx] <= addr_inc;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq -- directed self-checking bench for pc_seq
// ADDR_W=8, RESET_VEC=8'h10, STK_DEPTH=4, STK_PTR_W=3.
// Expected values are hand-computed; the PC_REL_BRANCH_EN variant of the
// branch expectations is selected with the same macro as the design.
// -----------------------------------------------------------------------------
module tb_pc_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       brnch_yes = 1'b0;
   logic       call = 1'b0;
   logic       ret = 1'b0;
   logic [7:0] regBuf = 8'h00;
   logic [7:0] addr;
   logic [2:0] stk_cnt;
   logic       stk_ovf;
   logic       stk_unf;

   int n_checks = 0;
   int n_pass   = 0;

   pc_seq #(
      .ADDR_W    (8),
      .RESET_VEC (8'h10),
      .STK_DEPTH (4),
      .STK_PTR_W (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .brnch_yes (brnch_yes),
      .call      (call),
      .ret       (ret),
      .regBuf    (regBuf),
      .addr      (addr),
      .stk_cnt   (stk_cnt),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic r, input logic e, input logic b,
                      input logic c, input logic rt, input logic [7:0] rb);
      rst = r; en = e; brnch_yes = b; call = c; ret = rt; regBuf = rb;
      @(posedge clk);
      #1;
      rst = 1'b0; brnch_yes = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   // Move from a known address to a target via the branch path.
   task automatic goto(input logic [7:0] from, input logic [7:0] to);
`ifdef PC_REL_BRANCH_EN
      cyc(0, 1, 1, 0, 0, to - from);
`else
      cyc(0, 1, 1, 0, 0, to);
`endif
      n_checks++;
      if (addr !== to) $display("FAIL goto: addr=%h expected=%h", addr, to);
      else n_pass++;
   endtask

   task automatic test_reset;
      cyc(1, 1, 1, 1, 0, 8'hAA);
      n_checks++;
      if ({addr, stk_cnt, stk_ovf, stk_unf} !== {8'h10, 3'd0, 1'b0, 1'b0})
         $display("FAIL reset: addr=%h cnt=%0d ovf=%b unf=%b expected 10/0/0/0",
                  addr, stk_cnt, stk_ovf, stk_unf);
      else n_pass++;
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 1, 0, 0, 0, 8'h00);
         n_checks++;
         if (addr !== 8'(8'h10 + i))
            $display("FAIL increment_%0d: addr=%h expected=%h", i, addr, 8'(8'h10 + i));
         else n_pass++;
      end
   endtask

   task automatic test_wrap_stall;
      goto(8'h13, 8'hFF);
      cyc(0, 1, 0, 0, 0, 8'h00);
      n_checks++;
      if (addr !== 8'h00) $display("FAIL wrap: addr=%h expected=00", addr);
      else n_pass++;
      // Stall with every strobe active: nothing moves.
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 1, 1, 1, 8'h40);
         n_checks++;
         if ({addr, stk_cnt, stk_ovf, stk_unf} !== {8'h00, 3'd0, 1'b0, 1'b0})
            $display("FAIL stall_%0d: addr=%h cnt=%0d ovf=%b unf=%b expected 00/0/0/0",
                     i, addr, stk_cnt, stk_ovf, stk_unf);
         else n_pass++;
      end
      // Stalled strobes are not remembered.
      cyc(0, 1, 0, 0, 0, 8'h40);
      n_checks++;
      if (addr !== 8'h01) $display("FAIL post_stall: addr=%h expected=01", addr);
      else n_pass++;
   endtask

   task automatic test_branch;
      goto(8'h01, 8'h05);
`ifdef PC_REL_BRANCH_EN
      cyc(0, 1, 1, 0, 0, 8'hFE);
      n_checks++;
      if (addr !== 8'h03) $display("FAIL branch_rel: addr=%h expected=03", addr);
      else n_pass++;
`else
      cyc(0, 1, 1, 0, 0, 8'h40);
      n_checks++;
      if (addr !== 8'h40) $display("FAIL branch_abs: addr=%h expected=40", addr);
      else n_pass++;
`endif
   endtask

   task automatic test_call_ret;
      logic [7:0] exp_a [5];
      logic [2:0] exp_c [5];
      logic [4:0] ops_c;
      logic [4:0] ops_r;
      logic [7:0] tgt [5];
`ifdef PC_REL_BRANCH_EN
      goto(8'h03, 8'h02);
`else
      goto(8'h40, 8'h02);
`endif
      // call 20, step, call 30, ret, ret
      exp_a = '{8'h20, 8'h21, 8'h30, 8'h22, 8'h03};
      exp_c = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd0};
      tgt   = '{8'h20, 8'h00, 8'h30, 8'h00, 8'h00};
      ops_c = 5'b00101;
      ops_r = 5'b11000;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, ops_c[i], ops_r[i], tgt[i]);
         n_checks++;
         if (addr !== exp_a[i] || stk_cnt !== exp_c[i])
            $display("FAIL nest_%0d: addr=%h cnt=%0d expected %h/%0d",
                     i, addr, stk_cnt, exp_a[i], exp_c[i]);
         else n_pass++;
      end
   endtask

   task automatic test_overflow;
      logic [7:0] rets [4];
      // At 03: pushes 04, 51, 52, 53; fifth call drops its push.
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 8'(8'h50 + i));
      n_checks++;
      if ({addr, stk_cnt, stk_ovf, stk_unf} !== {8'h54, 3'd4, 1'b1, 1'b0})
         $display("FAIL overflow: addr=%h cnt=%0d ovf=%b unf=%b expected 54/4/1/0",
                  addr, stk_cnt, stk_ovf, stk_unf);
      else n_pass++;
      rets = '{8'h53, 8'h52, 8'h51, 8'h04};
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 1, 8'h00);
         n_checks++;
         if (addr !== rets[i] || stk_cnt !== 3'(3 - i) || stk_ovf !== 1'b1)
            $display("FAIL pop_%0d: addr=%h cnt=%0d ovf=%b expected %h/%0d/1",
                     i, addr, stk_cnt, stk_ovf, rets[i], 3 - i);
         else n_pass++;
      end
      cyc(0, 1, 0, 0, 1, 8'h00);
      n_checks++;
      if ({addr, stk_cnt, stk_ovf, stk_unf} !== {8'h05, 3'd0, 1'b1, 1'b1})
         $display("FAIL underflow: addr=%h cnt=%0d ovf=%b unf=%b expected 05/0/1/1",
                  addr, stk_cnt, stk_ovf, stk_unf);
      else n_pass++;
   endtask

   task automatic test_strobes;
      cyc(0, 1, 0, 1, 0, 8'h70);   // at 05: push 06
      n_checks++;
      if (addr !== 8'h70 || stk_cnt !== 3'd1)
         $display("FAIL pre_sim: addr=%h cnt=%0d expected 70/1", addr, stk_cnt);
      else n_pass++;
      cyc(0, 1, 1, 1, 1, 8'h99);   // ret wins over call and branch
      n_checks++;
      if (addr !== 8'h06 || stk_cnt !== 3'd0)
         $display("FAIL call_ret_same: addr=%h cnt=%0d expected 06/0", addr, stk_cnt);
      else n_pass++;
      cyc(1, 1, 0, 1, 0, 8'h33);   // reset beats call
      n_checks++;
      if ({addr, stk_cnt, stk_ovf, stk_unf} !== {8'h10, 3'd0, 1'b0, 1'b0})
         $display("FAIL mid_reset: addr=%h cnt=%0d ovf=%b unf=%b expected 10/0/0/0",
                  addr, stk_cnt, stk_ovf, stk_unf);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      // call with branch: call's absolute target wins, return address 11.
      cyc(0, 1, 1, 1, 0, 8'hA0);
      n_checks++;
      if (addr !== 8'hA0 || stk_cnt !== 3'd1)
         $display("FAIL call_branch: addr=%h cnt=%0d expected A0/1", addr, stk_cnt);
      else n_pass++;
      cyc(0, 1, 0, 0, 1, 8'h00);
      n_checks++;
      if (addr !== 8'h11 || stk_cnt !== 3'd0)
         $display("FAIL ret_branch: addr=%h cnt=%0d expected 11/0", addr, stk_cnt);
      else n_pass++;
      // Return address pushed from FF wraps to 00.
      goto(8'h11, 8'hFF);
      cyc(0, 1, 0, 1, 0, 8'h20);
      cyc(0, 1, 0, 0, 1, 8'h00);
      n_checks++;
      if (addr !== 8'h00 || stk_cnt !== 3'd0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0)
         $display("FAIL push_wrap: addr=%h cnt=%0d ovf=%b unf=%b expected 00/0/0/0",
                  addr, stk_cnt, stk_ovf, stk_unf);
      else n_pass++;
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_wrap_stall;
      test_branch;
      test_call_ret;
      test_overflow;
      test_strobes;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
